eth_rx_mac_filter_fifo: RTL

//  Store-and-forward receive buffer with destination-MAC filtering for the byte-wide Ethernet RX path.

---
 rtl/eth_rx_mac_filter_fifo.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_mac_filter_fifo.sv
// Store-and-forward RX buffer with destination-MAC filtering.
// Frames are written speculatively and are only made visible to the read side once accepted whole.
module eth_rx_mac_filter_fifo #(
    parameter int DEPTH    = 2048,
    parameter int NUM_ADDR = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    input  logic [48*NUM_ADDR-1:0] cfg_mac_addr,
    input  logic [NUM_ADDR-1:0]   cfg_mac_en,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_promisc,
    output logic [CNT_W-1:0]      stat_frames_ok,
    output logic [CNT_W-1:0]      stat_frames_drop,
    output logic                  drop_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [47:0]      r_hdr, w_hdr_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic             r_match, w_match_calc;
    logic             r_s_rdy;
    logic [8:0]       r_mem [DEPTH];
    logic             r_s1_vld;
    logic [8:0]       r_s1_data;
    logic             r_m_vld, r_m_last;
    logic [7:0]       r_m_data;
    logic [CNT_W-1:0] r_ok, r_drop;
    logic             r_drop_pulse;

    logic w_acc, w_full, w_we, w_rewind, w_commit, w_drop, w_shift, w_match_ld;
    logic w_out_take, w_readable, w_s1_load;

    assign w_acc      = s_tvalid & r_s_rdy;
    assign w_full     = (r_wr_ptr - r_rd_ptr) == FULL_CNT;
    assign w_hdr_nxt  = {r_hdr[39:0], s_tdata};
    assign w_out_take = ~r_m_vld | m_tready;
    assign w_readable = r_rd_ptr != r_wr_commit;
    assign w_s1_load  = w_readable & (~r_s1_vld | w_out_take);

    always_comb begin
        w_match_calc = cfg_promisc | (cfg_bcast_en & (w_hdr_nxt == 48'hFFFF_FFFF_FFFF));
        for (int i = 0; i < NUM_ADDR; i++) begin
            if (cfg_mac_en[i] && (w_hdr_nxt == cfg_mac_addr[48*i +: 48]))
                w_match_calc = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_rewind    = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_shift     = 1'b0;
        w_match_ld  = 1'b0;
        if (w_acc) begin
            if (r_state == S_DROP) begin
                if (s_tlast) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end else if (w_full) begin
                w_rewind = 1'b1;
                if (s_tlast) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end else begin
                w_we = 1'b1;
                case (r_state)
                    S_IDLE: begin
                        w_shift   = 1'b1;
                        w_cnt_nxt = 3'd1;
                        if (s_tlast) begin
                            w_rewind = 1'b1;
                            w_drop   = 1'b1;
                        end else begin
                            w_state_nxt = S_HDR;
                        end
                    end
                    S_HDR: begin
                        w_shift = 1'b1;
                        if (r_cnt == 3'd5) begin
                            // last address byte: the filter decision is frozen here
                            w_match_ld = 1'b1;
                            if (s_tlast) begin
                                w_state_nxt = S_IDLE;
                                if (w_match_calc) begin
                                    w_commit = 1'b1;
                                end else begin
                                    w_rewind = 1'b1;
                                    w_drop   = 1'b1;
                                end
                            end else begin
                                w_state_nxt = S_BODY;
                            end
                        end else if (s_tlast) begin
                            w_rewind    = 1'b1;
                            w_drop      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                    S_BODY: begin
                        if (s_tlast) begin
                            w_state_nxt = S_IDLE;
                            if (r_match) begin
                                w_commit = 1'b1;
                            end else begin
                                w_rewind = 1'b1;
                                w_drop   = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hdr        <= '0;
            r_match      <= 1'b0;
            r_s_rdy      <= 1'b0;
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_rd_ptr     <= '0;
            r_s1_vld     <= 1'b0;
            r_m_vld      <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_ok         <= '0;
            r_drop       <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_s_rdy      <= 1'b1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_drop_pulse <= w_drop;
            if (w_shift)    r_hdr   <= w_hdr_nxt;
            if (w_match_ld) r_match <= w_match_calc;
            if (w_rewind)
                r_wr_ptr <= r_wr_commit;
            else if (w_we)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit)
                r_wr_commit <= r_wr_ptr + 1'b1;
            if (w_commit && (r_ok != '1))   r_ok   <= r_ok + 1'b1;
            if (w_drop && (r_drop != '1))   r_drop <= r_drop + 1'b1;
            // two-stage read: memory read register feeding the FWFT output register
            if (w_s1_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_s1_vld <= w_s1_load | (r_s1_vld & ~w_out_take);
            if (w_out_take) begin
                r_m_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_m_data <= r_s1_data[7:0];
                    r_m_last <= r_s1_data[8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)      r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
        if (w_s1_load) r_s1_data <= r_mem[r_rd_ptr[AW-1:0]];
    end

    assign s_tready         = r_s_rdy;
    assign m_tvalid         = r_m_vld;
    assign m_tdata          = r_m_data;
    assign m_tlast          = r_m_last;
    assign stat_frames_ok   = r_ok;
    assign stat_frames_drop = r_drop;
    assign drop_pulse       = r_drop_pulse;
endmodule
